// File: rtl/sprite_anim_ctrl_pkg.sv
// Shared types and helpers for the sprite animation controller.
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } anim_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // First ROM word of animation frame idx; frames are stored back-to-back.
  function automatic logic [31:0] frame_base(input logic [31:0] idx,
                                             input logic [31:0] frame_size);
    return idx * frame_size;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl_if.sv
// Bundle of pixel position, animation control and ROM-side signals.
interface sprite_anim_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int HOLD_W = 6,
  parameter int FIDX_W = 2
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              frame_start;
  logic              play;
  logic              stop;
  logic              loop;
  logic [HOLD_W-1:0] hold_frames;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [ADDR_W-1:0] rom_address;
  logic              in_window;
  logic [FIDX_W-1:0] frame_idx;
  logic              busy;
  logic              done;

  // Timing generator / host side.
  modport master (
    output DrawX, DrawY, frame_start, play, stop, loop, hold_frames, pos_x, pos_y,
    input  rom_address, in_window, frame_idx, busy, done
  );

  // Controller side.
  modport slave (
    input  DrawX, DrawY, frame_start, play, stop, loop, hold_frames, pos_x, pos_y,
    output rom_address, in_window, frame_idx, busy, done
  );
endinterface

// File: rtl/sprite_anim_ctrl_addr_gen.sv
// Sprite window compare and ROM address generation, one register stage.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 100,
  parameter int SPR_H      = 100,
  parameter int NUM_FRAMES = 4,
  parameter int ADDR_W     = 16,
  parameter int FIDX_W     = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic [FIDX_W-1:0] frame_idx,
  output logic [ADDR_W-1:0] rom_address,
  output logic              in_window
);

  localparam logic [31:0] FRAME_SIZE = 32'(SPR_W * SPR_H);

  logic [10:0]       x_ext, y_ext, sx_ext, sy_ext;
  logic              in_x, in_y, win_next;
  logic [9:0]        dx, dy;
  logic [ADDR_W-1:0] base, offset, addr_next;

  // 11-bit compares so a window running past the screen edge never wraps.
  always_comb begin
    x_ext     = {1'b0, draw_x};
    y_ext     = {1'b0, draw_y};
    sx_ext    = {1'b0, sx};
    sy_ext    = {1'b0, sy};
    in_x      = (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPR_W));
    in_y      = (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPR_H));
    win_next  = in_x && in_y;
    dx        = draw_x - sx;
    dy        = draw_y - sy;
    base      = ADDR_W'(frame_base(32'(frame_idx), FRAME_SIZE));
    offset    = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
    addr_next = win_next ? base + offset : base;
  end

  // Register address and window flag together so they stay aligned.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_address <= '0;
      in_window   <= 1'b0;
    end else begin
      rom_address <= addr_next;
      in_window   <= win_next;
    end
  end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation sequencer: shadow registers, play/stop FSM, hold counter.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 100,
  parameter int SPR_H      = 100,
  parameter int NUM_FRAMES = 4,
  parameter int ADDR_W     = 16,
  parameter int HOLD_W     = 6,
  parameter int FIDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input logic               vga_clk,
  input logic               reset,
  sprite_anim_ctrl_if.slave bus
);

  localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);

  anim_state_t       state_reg, state_next;
  logic [FIDX_W-1:0] frame_reg, frame_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              done_reg, done_next;
  logic [9:0]        pos_x_reg, pos_y_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [HOLD_W-1:0] hold_last;

  // Latch position and hold only at vertical blank so a frame never tears.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pos_x_reg <= '0;
      pos_y_reg <= '0;
      hold_reg  <= '0;
    end else if (bus.frame_start) begin
      pos_x_reg <= bus.pos_x;
      pos_y_reg <= bus.pos_y;
      hold_reg  <= bus.hold_frames;
    end
  end

  // A hold of 0 is shown for one tick, same as a hold of 1.
  assign hold_last = (hold_reg == '0) ? '0 : hold_reg - 1'b1;

  // Sequencer state, frame index, hold counter and done pulse.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      frame_reg    <= '0;
      hold_cnt_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      frame_reg    <= frame_next;
      hold_cnt_reg <= hold_cnt_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic; user commands take priority over a vertical tick.
  always_comb begin
    state_next    = state_reg;
    frame_next    = frame_reg;
    hold_cnt_next = hold_cnt_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        frame_next    = '0;
        hold_cnt_next = '0;
        if (!bus.stop && bus.play) state_next = PLAY;
      end
      PLAY: begin
        if (bus.stop) begin
          state_next    = IDLE;
          frame_next    = '0;
          hold_cnt_next = '0;
        end else if (bus.play) begin
          frame_next    = '0;
          hold_cnt_next = '0;
        end else if (bus.frame_start) begin
          // >= keeps the count bounded if the hold shrinks mid-frame.
          if (hold_cnt_reg >= hold_last) begin
            hold_cnt_next = '0;
            if (frame_reg == LAST_FRAME) begin
              if (bus.loop) begin
                frame_next = '0;
              end else begin
                state_next = DONE;
                done_next  = 1'b1;
              end
            end else begin
              frame_next = frame_reg + 1'b1;
            end
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.stop) begin
          state_next    = IDLE;
          frame_next    = '0;
          hold_cnt_next = '0;
        end else if (bus.play) begin
          state_next    = PLAY;
          frame_next    = '0;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        frame_next    = '0;
        hold_cnt_next = '0;
      end
    endcase
  end

  assign bus.frame_idx = frame_reg;
  assign bus.busy      = (state_reg == PLAY);
  assign bus.done      = done_reg;

  sprite_addr_gen #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .NUM_FRAMES (NUM_FRAMES),
    .ADDR_W     (ADDR_W),
    .FIDX_W     (FIDX_W)
  ) u_addr_gen (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .draw_x      (bus.DrawX),
    .draw_y      (bus.DrawY),
    .sx          (pos_x_reg),
    .sy          (pos_y_reg),
    .frame_idx   (frame_reg),
    .rom_address (bus.rom_address),
    .in_window   (bus.in_window)
  );

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Testbench for sprite_anim_ctrl: address table plus sequencer scenarios.
module tb_sprite_anim_ctrl;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  sprite_anim_ctrl_if #(.ADDR_W(16), .HOLD_W(6), .FIDX_W(2)) bus ();

  sprite_anim_ctrl #(
    .SPR_W(100), .SPR_H(100), .NUM_FRAMES(4), .ADDR_W(16), .HOLD_W(6)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int px; int py; int x; int y; int addr; int win;
  } vec_t;
  typedef struct {
    int addr; int win;
  } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;

  task automatic tick();
    @(posedge vga_clk);
    #1;
    if (bus.done) done_cnt++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic cmd_play();
    bus.play = 1'b1;
    tick();
    bus.play = 1'b0;
  endtask

  initial begin
    int   loop_seq[10];
    exp_t e;

    bus.DrawX = '0; bus.DrawY = '0; bus.frame_start = 1'b0;
    bus.play = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
    bus.hold_frames = '0; bus.pos_x = '0; bus.pos_y = '0;

    vecs[0] = '{0,   0,   5,   2,   205,  1};
    vecs[1] = '{300, 200, 399, 299, 9999, 1};
    vecs[2] = '{300, 200, 400, 299, 0,    0};
    vecs[3] = '{300, 200, 300, 200, 0,    1};
    vecs[4] = '{300, 200, 299, 250, 0,    0};
    vecs[5] = '{300, 200, 350, 300, 0,    0};
    vecs[6] = '{600, 450, 639, 479, 2939, 1};
    vecs[7] = '{0,   0,   99,  99,  9999, 1};
    vecs[8] = '{0,   0,   100, 0,   0,    0};
    vecs[9] = '{10,  20,  15,  25,  505,  1};
    loop_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    // Reset state.
    tick();
    chk("rst_frame", int'(bus.frame_idx), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_addr", int'(bus.rom_address), 0);
    chk("rst_win", int'(bus.in_window), 0);
    reset = 1'b0;
    tick();
    chk("idle_frame", int'(bus.frame_idx), 0);
    chk("idle_busy", int'(bus.busy), 0);

    // Address table, frame 0 in IDLE; position latched by a frame_start first.
    for (int i = 0; i < 10; i++) begin
      bus.pos_x = 10'(vecs[i].px);
      bus.pos_y = 10'(vecs[i].py);
      pulse_fs();
      bus.DrawX = 10'(vecs[i].x);
      bus.DrawY = 10'(vecs[i].y);
      exp_q.push_back('{vecs[i].addr, vecs[i].win});
      tick();
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_addr", i), int'(bus.rom_address), e.addr);
      chk($sformatf("vec%0d_win", i), int'(bus.in_window), e.win);
    end

    // Looping playback, hold=2.
    bus.pos_x = '0; bus.pos_y = '0; bus.DrawX = '0; bus.DrawY = '0;
    bus.hold_frames = 6'd2; bus.loop = 1'b1;
    pulse_fs();
    cmd_play();
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("loop_frame%0d", i), int'(bus.frame_idx), loop_seq[i]);
      chk($sformatf("loop_busy%0d", i), int'(bus.busy), 1);
      pulse_fs();
    end
    chk("loop_no_done", done_cnt, 0);

    // stop with frame_start: stop wins, hold=1 still latched.
    bus.hold_frames = 6'd1; bus.loop = 1'b0;
    bus.stop = 1'b1; bus.frame_start = 1'b1;
    tick();
    bus.stop = 1'b0; bus.frame_start = 1'b0;
    chk("stopfs_frame", int'(bus.frame_idx), 0);
    chk("stopfs_busy", int'(bus.busy), 0);

    // One-shot playback, hold=1.
    cmd_play();
    done_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      pulse_fs();
      if (k < 4) begin
        chk($sformatf("once_frame%0d", k), int'(bus.frame_idx), k);
        chk($sformatf("once_busy%0d", k), int'(bus.busy), 1);
        chk($sformatf("once_nodone%0d", k), int'(bus.done), 0);
      end else begin
        chk("once_done", int'(bus.done), 1);
        chk("once_busy_end", int'(bus.busy), 0);
        chk("once_frame_end", int'(bus.frame_idx), 3);
      end
    end
    tick();
    tick();
    chk("once_done_cnt", done_cnt, 1);
    chk("once_hold_frame", int'(bus.frame_idx), 3);
    chk("once_addr", int'(bus.rom_address), 30000);
    chk("once_win", int'(bus.in_window), 1);

    // hold=0 acts as hold=1.
    bus.hold_frames = 6'd0;
    bus.stop = 1'b1; bus.frame_start = 1'b1;
    tick();
    bus.stop = 1'b0; bus.frame_start = 1'b0;
    cmd_play();
    pulse_fs();
    chk("hold0_frame1", int'(bus.frame_idx), 1);
    pulse_fs();
    chk("hold0_frame2", int'(bus.frame_idx), 2);

    // play with frame_start: restart, no advance.
    bus.play = 1'b1; bus.frame_start = 1'b1;
    tick();
    bus.play = 1'b0; bus.frame_start = 1'b0;
    chk("playfs_frame", int'(bus.frame_idx), 0);
    chk("playfs_busy", int'(bus.busy), 1);

    // play and stop together: stop wins.
    bus.play = 1'b1; bus.stop = 1'b1;
    tick();
    bus.play = 1'b0; bus.stop = 1'b0;
    chk("playstop_busy", int'(bus.busy), 0);
    chk("playstop_frame", int'(bus.frame_idx), 0);

    // Position change takes effect only after the next frame_start.
    bus.pos_x = 10'd50; bus.DrawX = 10'd10; bus.DrawY = 10'd0;
    tick();
    chk("shadow_old_win", int'(bus.in_window), 1);
    chk("shadow_old_addr", int'(bus.rom_address), 10);
    pulse_fs();
    tick();
    chk("shadow_new_out_win", int'(bus.in_window), 0);
    chk("shadow_new_out_addr", int'(bus.rom_address), 0);
    bus.DrawX = 10'd50;
    tick();
    chk("shadow_new_edge_win", int'(bus.in_window), 1);
    bus.DrawX = 10'd51;
    tick();
    chk("shadow_new_addr", int'(bus.rom_address), 1);

    // Async reset mid-play.
    cmd_play();
    pulse_fs();
    pulse_fs();
    bus.DrawX = 10'd60; bus.DrawY = 10'd5;
    tick();
    chk("pre_rst_addr", int'(bus.rom_address), 20510);
    done_cnt = 0;
    reset = 1'b1;
    #1;
    chk("arst_frame", int'(bus.frame_idx), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_addr", int'(bus.rom_address), 0);
    chk("arst_win", int'(bus.in_window), 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle_busy", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
